// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the instruction ROM read port between the fetch stage
// (port A, single words) and the loader/debug burst reader (port B).
// Round-robin arbitration per cycle, one ROM read per cycle, the response is
// registered and returned one cycle later on the winning port. Misaligned
// and out-of-range addresses return 0 with the error flag set.
module rom_arbiter #(
    parameter int profundidad = 1024,
    parameter int MAXLEN      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    // fetch port
    input  logic                           a_req,
    input  logic [31:0]                    a_addr,
    output logic                           a_gnt,
    output logic                           a_rvalid,
    output logic [31:0]                    a_rdata,
    output logic                           a_err,
    // burst port
    input  logic                           b_start,
    input  logic [31:0]                    b_base,
    input  logic [$clog2(MAXLEN):0]        b_len,
    output logic                           b_busy,
    output logic                           b_rvalid,
    output logic [31:0]                    b_rdata,
    output logic                           b_err,
    output logic                           b_done,
    // ROM
    output logic [$clog2(profundidad)-1:0] rom_addr,
    input  logic [31:0]                    rom_data
);

    localparam int AW = $clog2(profundidad);
    localparam int LW = $clog2(MAXLEN) + 1;

    typedef enum logic [1:0] {
        B_IDLE,
        B_BUSY,
        B_DRAIN
    } bstate_t;

    // Misaligned, or the full word index (not just the ROM-sized slice) is
    // past the end of the ROM; wrapped burst addresses are caught here too.
    function automatic logic addr_bad(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (idx >= 32'(profundidad));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return addr[AW+1:2];
    endfunction

    // A zero length still moves one word; anything above MAXLEN is clamped.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len == '0) begin
            return LW'(1);
        end
        if (len > LW'(MAXLEN)) begin
            return LW'(MAXLEN);
        end
        return len;
    endfunction

    bstate_t        state;
    logic [31:0]    cur;
    logic [LW-1:0]  remaining;
    logic           rr;

    logic           a_want_p0;
    logic           b_want_p0;
    logic           a_win_p0;
    logic           b_win_p0;
    logic [31:0]    sel_addr_p0;
    logic           sel_err_p0;
    logic [31:0]    sel_data_p0;

    // Issue stage: pick the winner, drive the ROM address, qualify the read word.
    // No grant is given while reset is high, since its response would be dropped.
    always_comb begin
        a_want_p0 = a_req && !reset;
        b_want_p0 = (state == B_BUSY) && !reset;
        a_win_p0  = 1'b0;
        b_win_p0  = 1'b0;
        if (a_want_p0 && b_want_p0) begin
            a_win_p0 = !rr;
            b_win_p0 = rr;
        end else begin
            a_win_p0 = a_want_p0;
            b_win_p0 = b_want_p0;
        end
        sel_addr_p0 = b_win_p0 ? cur : a_addr;
        sel_err_p0  = addr_bad(sel_addr_p0);
        sel_data_p0 = sel_err_p0 ? 32'h0 : rom_data;
        rom_addr    = (a_win_p0 || b_win_p0) ? word_idx(sel_addr_p0) : '0;
    end

    assign a_gnt = a_win_p0;

    // Response control: valid and error for the winning port, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
        end else begin
            a_rvalid <= a_win_p0;
            a_err    <= a_win_p0 && sel_err_p0;
            b_rvalid <= b_win_p0;
            b_err    <= b_win_p0 && sel_err_p0;
        end
    end

    // Response data: zero for a port that did not win, so it is also zero after reset.
    always_ff @(posedge clk) begin
        a_rdata <= a_win_p0 ? sel_data_p0 : 32'h0;
        b_rdata <= b_win_p0 ? sel_data_p0 : 32'h0;
    end

    // Burst FSM and round-robin pointer; the loser of a contested slot gets priority next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= B_IDLE;
            b_busy    <= 1'b0;
            b_done    <= 1'b0;
            cur       <= 32'h0;
            remaining <= '0;
            rr        <= 1'b0;
        end else begin
            b_done <= 1'b0;
            if (a_want_p0 && b_want_p0) begin
                rr <= a_win_p0;
            end
            case (state)
                B_IDLE: begin
                    if (b_start) begin
                        cur       <= b_base;
                        remaining <= clamp_len(b_len);
                        state     <= B_BUSY;
                        b_busy    <= 1'b1;
                    end
                end
                B_BUSY: begin
                    if (b_win_p0) begin
                        cur       <= cur + 32'd4;
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state  <= B_DRAIN;
                            b_done <= 1'b1;
                        end
                    end
                end
                B_DRAIN: begin
                    state  <= B_IDLE;
                    b_busy <= 1'b0;
                end
                default: begin
                    state  <= B_IDLE;
                    b_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: cycle-level scoreboard bench for rom_arbiter.
// Expected responses are queued when a request is issued and compared when
// the registered response appears one cycle later.
module tb_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req;
    logic [31:0] a_addr;
    logic        a_gnt;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        a_err;
    logic        b_start;
    logic [31:0] b_base;
    logic [4:0]  b_len;
    logic        b_busy;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_err;
    logic        b_done;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];

    int n_cmp = 0;
    int n_mis = 0;

    // spec-level model state
    int          m_state = 0;   // 0 idle, 1 busy, 2 drain
    logic [31:0] m_cur = 32'h0;
    int          m_rem = 0;
    logic        m_rr = 1'b0;
    logic        a_granted = 1'b0;
    logic        was_reset = 1'b0;
    int          cyc = 0;
    int          bdone_cyc = -1;
    int          b_words = 0;

    function automatic logic [31:0] rom_fn(input logic [9:0] i);
        return {i, 2'b00, ~i, 2'b11, i[7:0]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    rom_arbiter #(.profundidad(1024), .MAXLEN(16)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_start(b_start), .b_base(b_base), .b_len(b_len),
        .b_busy(b_busy), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .b_err(b_err), .b_done(b_done),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] addr, input logic last);
        rsp_t r;
        r.err  = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd1024);
        r.data = r.err ? 32'h0 : rom_fn(addr[11:2]);
        r.last = last;
        return r;
    endfunction

    // One clock cycle: check outputs at negedge, predict the issue, advance model.
    task automatic cycle();
        rsp_t e;
        logic aw, bw, wa, wb;
        logic [31:0] ia;
        @(negedge clk);
        if (was_reset && !reset) begin
            check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
            check("rst_a_rdata",  a_rdata,       32'h0);
            check("rst_a_err",    32'(a_err),    32'h0);
            check("rst_b_rvalid", 32'(b_rvalid), 32'h0);
            check("rst_b_rdata",  b_rdata,       32'h0);
            check("rst_b_err",    32'(b_err),    32'h0);
            check("rst_b_done",   32'(b_done),   32'h0);
            check("rst_b_busy",   32'(b_busy),   32'h0);
        end
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_rvalid", 32'(a_rvalid), 32'h1);
            check("a_rdata",  a_rdata,       e.data);
            check("a_err",    32'(a_err),    32'(e.err));
        end else begin
            check("a_rvalid_quiet", 32'(a_rvalid), 32'h0);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_rvalid", 32'(b_rvalid), 32'h1);
            check("b_rdata",  b_rdata,       e.data);
            check("b_err",    32'(b_err),    32'(e.err));
            check("b_done",   32'(b_done),   32'(e.last));
            b_words++;
            if (e.last) bdone_cyc = cyc;
        end else begin
            check("b_rvalid_quiet", 32'(b_rvalid), 32'h0);
            check("b_done_quiet",   32'(b_done),   32'h0);
        end
        check("b_busy", 32'(b_busy), 32'(m_state != 0));

        aw = a_req && !reset;
        bw = (m_state == 1) && !reset;
        if (aw && bw) begin
            wa = !m_rr;
            wb = m_rr;
        end else begin
            wa = aw;
            wb = bw;
        end
        check("a_gnt", 32'(a_gnt), 32'(wa));
        ia = wb ? m_cur : a_addr;
        check("rom_addr", 32'(rom_addr), (wa || wb) ? 32'(ia[11:2]) : 32'h0);
        if (wa) qa.push_back(mk(a_addr, 1'b0));
        if (wb) qb.push_back(mk(m_cur, m_rem == 1));
        a_granted = wa;

        if (reset) begin
            m_state = 0;
            m_rr    = 1'b0;
            m_rem   = 0;
        end else begin
            if (aw && bw) m_rr = wa;
            case (m_state)
                0: if (b_start) begin
                    m_state = 1;
                    m_cur   = b_base;
                    m_rem   = (b_len == 0) ? 1 : (b_len > 16) ? 16 : int'(b_len);
                end
                1: if (wb) begin
                    m_cur = m_cur + 32'd4;
                    m_rem--;
                    if (m_rem == 0) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
        was_reset = reset;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr);
        int guard;
        guard  = 0;
        a_req  = 1'b1;
        a_addr = addr;
        do begin
            cycle();
            guard++;
        end while (!a_granted && guard < 50);
        if (!a_granted) check("fetch_timeout", 32'h0, 32'h1);
        a_req = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((m_state != 0 || qa.size() > 0 || qb.size() > 0) && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) check("idle_timeout", 32'h0, 32'h1);
        cycle();
    endtask

    // Pulses b_start for one cycle; returns the cycle index of the pulse.
    task automatic start_burst(input logic [31:0] base, input logic [4:0] len, output int s);
        b_start   = 1'b1;
        b_base    = base;
        b_len     = len;
        bdone_cyc = -1;
        b_words   = 0;
        s         = cyc;
        cycle();
        b_start   = 1'b0;
    endtask

    initial begin
        int s;
        reset   = 1'b1;
        a_req   = 1'b0;
        a_addr  = 32'h0;
        b_start = 1'b0;
        b_base  = 32'h0;
        b_len   = 5'd0;
        cycle();
        cycle();
        reset = 1'b0;

        // single fetches: good, misaligned, out of range
        fetch(32'h0000_0008);
        cycle();
        fetch(32'h0000_0006);
        fetch(32'h0000_1000);
        fetch(32'h0000_0FFC);
        cycle();

        // back-to-back fetches, one per cycle
        a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 32'h20 + 32'(i) * 4;
            cycle();
        end
        a_req = 1'b0;
        cycle();

        // uncontested burst of 4 words from 0x10
        start_burst(32'h0000_0010, 5'd4, s);
        wait_idle();
        check("b4_words", 32'(b_words), 32'd4);
        check("b4_done_cyc", 32'(bdone_cyc), 32'(s + 5));

        // burst of 3 against continuous fetch traffic
        start_burst(32'h0000_0200, 5'd3, s);
        a_req  = 1'b1;
        a_addr = 32'h0000_0040;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (a_granted) a_addr = a_addr + 32'd4;
        end
        a_req = 1'b0;
        wait_idle();
        check("contend_words", 32'(b_words), 32'd3);
        check("contend_done_cyc", 32'(bdone_cyc), 32'(s + 7));

        // reset two cycles into a burst of 8
        start_burst(32'h0000_0100, 5'd8, s);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_idle();
        check("rst_burst_words", 32'(b_words), 32'd2);
        check("rst_burst_no_done", 32'(bdone_cyc), 32'hFFFF_FFFF);
        start_burst(32'h0000_0300, 5'd2, s);
        wait_idle();
        check("post_rst_words", 32'(b_words), 32'd2);

        // length edge cases
        start_burst(32'h0000_0400, 5'd0, s);
        wait_idle();
        check("len0_words", 32'(b_words), 32'd1);
        check("len0_done_cyc", 32'(bdone_cyc), 32'(s + 2));
        start_burst(32'h0000_0800, 5'd31, s);
        wait_idle();
        check("len31_words", 32'(b_words), 32'd16);

        // b_start while busy is ignored
        start_burst(32'h0000_0600, 5'd5, s);
        cycle();
        b_start = 1'b1;
        b_base  = 32'h0000_0000;
        b_len   = 5'd2;
        cycle();
        b_start = 1'b0;
        wait_idle();
        check("restart_ignored_words", 32'(b_words), 32'd5);

        // address wrap past 0xFFFF_FFFC and a misaligned burst
        start_burst(32'hFFFF_FFF8, 5'd4, s);
        wait_idle();
        check("wrap_words", 32'(b_words), 32'd4);
        start_burst(32'h0000_0003, 5'd2, s);
        wait_idle();
        check("misalign_burst_words", 32'(b_words), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
